id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-002 SHALL have decode inputs: id_valid 1; id_rs_data 32; id_rt_data 32; id_imm32 32; id_shamt 5; id_rs 5; id_rt 5; id_rd 5; id_alufun 6; id_sign 1; id_alusrc1 1 (A = {27'b0,shamt}); id_alusrc2 1 (B = imm32); id_regwrite 1; id_memread 1.
REQ-003 SHALL have forwarding inputs: mem_regwrite 1, mem_rd 5, mem_result 32; wb_regwrite 1, wb_rd 5, wb_result 32.
REQ-004 SHALL have control inputs: stall 1 (downstream hold); flush 1 (squash decode instruction).
REQ-005 SHALL have outputs: ex_valid 1; ex_a 32; ex_b 32; ex_alufun 6; ex_sign 1; ex_rd 5; ex_regwrite 1; ex_memread 1; ex_store_data 32 (forwarded rt); load_use_stall 1.

Function
REQ-006 SHALL hold one registered slot: valid, rs_data, rt_data, imm32, shamt, rs, rt, rd, alufun, sign, alusrc1, alusrc2, regwrite, memread.
REQ-007 Slot SHALL load decode inputs on a clock edge when stall=0, flush=0, load_use_stall=0; latency decode-to-EX is exactly 1 cycle.
REQ-008 flush=1 with stall=0 SHALL load a bubble: valid=0, regwrite=0, memread=0, other fields don't-care.
REQ-009 load_use_stall=1 with stall=0 SHALL load a bubble as in REQ-008 (decode must hold its instruction).
REQ-010 stall=1 SHALL override flush and load_use_stall: slot control fields hold; rs_data/rt_data SHALL be rewritten with the forwarded values of REQ-012 so forwarded data is not lost while held.
REQ-011 load_use_stall SHALL be combinational: valid & memread & rd!=0 & id_valid & (rd==id_rs | rd==id_rt).
REQ-012 Forwarded rs value fwd_rs SHALL be: mem_result if mem_regwrite & mem_rd==rs & rs!=0; else wb_result if wb_regwrite & wb_rd==rs & rs!=0; else registered rs_data. fwd_rt identical using rt.
REQ-013 MEM forwarding SHALL take priority over WB when both match.
REQ-014 Register 0 SHALL never be forwarded; rs=0 yields registered rs_data.
REQ-015 ex_a SHALL be {27'b0,shamt} when alusrc1=1, else fwd_rs; ex_b SHALL be imm32 when alusrc2=1, else fwd_rt.
REQ-016 ex_store_data SHALL equal fwd_rt regardless of alusrc2.
REQ-017 ex_alufun, ex_sign, ex_rd SHALL be registered fields directly; ex_regwrite and ex_memread SHALL be gated by valid.
REQ-018 ex_a/ex_b SHALL be combinational from registered state and forwarding inputs; no extra cycle.
REQ-019 id_valid=0 SHALL load a bubble as in REQ-008.

Reset
REQ-020 reset=0 SHALL asynchronously clear all slot fields to 0; ex_valid, ex_regwrite, ex_memread, load_use_stall=0, ex_a=ex_b=0, ex_alufun=6'b000000.
REQ-021 Release of reset SHALL take effect at the next rising clk; first capture occurs on that edge.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-023 Plain ADD: id_rs_data=5, id_rt_data=7, srcs=0, no forwarding -> next cycle ex_a=5, ex_b=7, ex_valid=1.
REQ-024 Priority: rs=3, mem_rd=3 mem_result=0x11, wb_rd=3 wb_result=0x22, both regwrite=1 -> ex_a=0x11; drop MEM match -> 0x22; rs=0 with matches -> registered rs_data.
REQ-025 Load-use: EX holds memread=1 rd=8; id_rt=8 id_valid=1 -> load_use_stall=1; next edge ex_valid=0, ex_regwrite=0.
REQ-026 Stall with forwarding: stall=1 two cycles, wb_result=0x55 to rs only in first cycle -> ex_a stays 0x55 in second cycle.
REQ-027 Stall+flush same cycle -> slot held, ex_valid unchanged; flush alone -> ex_valid=0 next cycle.
REQ-028 Async reset mid-operation (between edges) -> ex_valid=0 and ex_a=0 immediately, no clock needed.

Source files
------------

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// id_ex_stage_if
// Decode-side, forwarding, control and EX-side signals of the ID/EX pipeline
// register, bundled so the stage and its environment share one connection.
// Revision: 1.0
// ============================================================================
interface id_ex_stage_if;
    // Decode instruction
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm32;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [5:0]  id_alufun;
    logic        id_sign;
    logic        id_alusrc1;
    logic        id_alusrc2;
    logic        id_regwrite;
    logic        id_memread;
    // Forwarding sources
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    // Pipeline control
    logic        stall;
    logic        flush;
    // EX-side results
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [5:0]  ex_alufun;
    logic        ex_sign;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [31:0] ex_store_data;
    logic        load_use_stall;

    // Environment side: drives decode/forwarding/control, observes EX
    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt,
               id_rd, id_alufun, id_sign, id_alusrc1, id_alusrc2, id_regwrite,
               id_memread, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd,
               wb_result, stall, flush,
        input  ex_valid, ex_a, ex_b, ex_alufun, ex_sign, ex_rd, ex_regwrite,
               ex_memread, ex_store_data, load_use_stall
    );

    // Stage side
    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt,
               id_rd, id_alufun, id_sign, id_alusrc1, id_alusrc2, id_regwrite,
               id_memread, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd,
               wb_result, stall, flush,
        output ex_valid, ex_a, ex_b, ex_alufun, ex_sign, ex_rd, ex_regwrite,
               ex_memread, ex_store_data, load_use_stall
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage
// ID/EX pipeline register with operand forwarding from MEM and WB, load-use
// hazard detection, flush/bubble insertion and downstream stall hold.
// Revision: 1.0
// ============================================================================
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,      // asynchronous, active low
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm32;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  alufun;
        logic        sign;
        logic        alusrc1;
        logic        alusrc2;
        logic        regwrite;
        logic        memread;
    } slot_t;

    slot_t       slot_q;
    slot_t       slot_d;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic        load_use;

    // Operand forwarding: MEM result is newer than WB, so it wins; r0 is hardwired
    always_comb begin
        fwd_rs = slot_q.rs_data;
        if (slot_q.rs != 5'd0 && bus.mem_regwrite && bus.mem_rd == slot_q.rs)
            fwd_rs = bus.mem_result;
        else if (slot_q.rs != 5'd0 && bus.wb_regwrite && bus.wb_rd == slot_q.rs)
            fwd_rs = bus.wb_result;

        fwd_rt = slot_q.rt_data;
        if (slot_q.rt != 5'd0 && bus.mem_regwrite && bus.mem_rd == slot_q.rt)
            fwd_rt = bus.mem_result;
        else if (slot_q.rt != 5'd0 && bus.wb_regwrite && bus.wb_rd == slot_q.rt)
            fwd_rt = bus.wb_result;
    end

    // Load in EX whose destination is a source of the decode instruction
    always_comb begin
        load_use = slot_q.valid && slot_q.memread && (slot_q.rd != 5'd0) && bus.id_valid &&
                   ((slot_q.rd == bus.id_rs) || (slot_q.rd == bus.id_rt));
    end

    // Slot next state: stall holds (refreshing operands), otherwise capture or bubble
    always_comb begin
        slot_d = slot_q;
        if (bus.stall) begin
            // Forwarding sources move on while we hold, so keep what they offered
            slot_d.rs_data = fwd_rs;
            slot_d.rt_data = fwd_rt;
        end else begin
            slot_d.valid    = bus.id_valid;
            slot_d.rs_data  = bus.id_rs_data;
            slot_d.rt_data  = bus.id_rt_data;
            slot_d.imm32    = bus.id_imm32;
            slot_d.shamt    = bus.id_shamt;
            slot_d.rs       = bus.id_rs;
            slot_d.rt       = bus.id_rt;
            slot_d.rd       = bus.id_rd;
            slot_d.alufun   = bus.id_alufun;
            slot_d.sign     = bus.id_sign;
            slot_d.alusrc1  = bus.id_alusrc1;
            slot_d.alusrc2  = bus.id_alusrc2;
            slot_d.regwrite = bus.id_regwrite;
            slot_d.memread  = bus.id_memread;
            if (bus.flush || load_use || !bus.id_valid) begin
                slot_d.valid    = 1'b0;
                slot_d.regwrite = 1'b0;
                slot_d.memread  = 1'b0;
            end
        end
    end

    // Slot register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    assign bus.ex_valid       = slot_q.valid;
    assign bus.ex_a           = slot_q.alusrc1 ? {27'b0, slot_q.shamt} : fwd_rs;
    assign bus.ex_b           = slot_q.alusrc2 ? slot_q.imm32 : fwd_rt;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_alufun      = slot_q.alufun;
    assign bus.ex_sign        = slot_q.sign;
    assign bus.ex_rd          = slot_q.rd;
    assign bus.ex_regwrite    = slot_q.valid & slot_q.regwrite;
    assign bus.ex_memread     = slot_q.valid & slot_q.memread;
    assign bus.load_use_stall = load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
// Revision: 1.0
// ============================================================================
module tb_id_ex_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_stage_if u_if ();

    id_ex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus optional expectations for that cycle
    typedef struct {
        logic        idv;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh, rs, rt, rd;
        logic [5:0]  fun;
        logic        sgn, s1, s2, rw, mr;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        stall, flush;
        logic        cd;                 // compare data outputs
        logic        ev, erw, elus;
        logic [31:0] ea, eb, est;
    } vec_t;

    // Architectural view of the instruction sitting in EX
    typedef struct {
        logic        valid;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh, rs, rt, rd;
        logic [5:0]  fun;
        logic        sgn, s1, s2, rw, mr;
    } mslot_t;

    mslot_t m;
    mslot_t m_nx;
    vec_t   tbl [11];
    vec_t   v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t ins(input logic idv, input logic [4:0] rs, input logic [31:0] rsd,
                                 input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                                 input logic s1, input logic [4:0] sh, input logic s2,
                                 input logic [31:0] imm, input logic rw, input logic mr);
        vec_t r;
        r = '{default: '0};
        r.idv = idv; r.rs = rs; r.rsd = rsd; r.rt = rt; r.rtd = rtd; r.rd = rd;
        r.s1 = s1; r.sh = sh; r.s2 = s2; r.imm = imm; r.rw = rw; r.mr = mr;
        r.fun = 6'h21; r.sgn = 1'b1;
        return r;
    endfunction

    function automatic vec_t fw(input vec_t x, input logic mrw, input logic [4:0] mrd,
                                input logic [31:0] mres, input logic wrw, input logic [4:0] wrd,
                                input logic [31:0] wres);
        vec_t r;
        r = x;
        r.mrw = mrw; r.mrd = mrd; r.mres = mres; r.wrw = wrw; r.wrd = wrd; r.wres = wres;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t x, input logic cd, input logic ev, input logic erw,
                                input logic elus, input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] est);
        vec_t r;
        r = x;
        r.cd = cd; r.ev = ev; r.erw = erw; r.elus = elus; r.ea = ea; r.eb = eb; r.est = est;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        u_if.id_valid     = x.idv;
        u_if.id_rs_data   = x.rsd;
        u_if.id_rt_data   = x.rtd;
        u_if.id_imm32     = x.imm;
        u_if.id_shamt     = x.sh;
        u_if.id_rs        = x.rs;
        u_if.id_rt        = x.rt;
        u_if.id_rd        = x.rd;
        u_if.id_alufun    = x.fun;
        u_if.id_sign      = x.sgn;
        u_if.id_alusrc1   = x.s1;
        u_if.id_alusrc2   = x.s2;
        u_if.id_regwrite  = x.rw;
        u_if.id_memread   = x.mr;
        u_if.mem_regwrite = x.mrw;
        u_if.mem_rd       = x.mrd;
        u_if.mem_result   = x.mres;
        u_if.wb_regwrite  = x.wrw;
        u_if.wb_rd        = x.wrd;
        u_if.wb_result    = x.wres;
        u_if.stall        = x.stall;
        u_if.flush        = x.flush;
    endtask

    // Value a source register really holds, given what is in flight downstream
    function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] held, input vec_t x);
        if (r != 5'd0 && x.mrw && x.mrd == r) return x.mres;
        if (r != 5'd0 && x.wrw && x.wrd == r) return x.wres;
        return held;
    endfunction

    // Drive one cycle, compare against the model, and compute the model's next state
    task automatic mc_drive(input vec_t x);
        logic        lus;
        logic [31:0] fa, fb;
        drive(x);
        #3;
        lus = m.valid && m.mr && (m.rd != 5'd0) && x.idv && (m.rd == x.rs || m.rd == x.rt);
        fa  = fwd_val(m.rs, m.rsd, x);
        fb  = fwd_val(m.rt, m.rtd, x);
        chk("m_valid", 32'(u_if.ex_valid), 32'(m.valid));
        chk("m_regwrite", 32'(u_if.ex_regwrite), 32'(m.valid & m.rw));
        chk("m_memread", 32'(u_if.ex_memread), 32'(m.valid & m.mr));
        chk("m_load_use", 32'(u_if.load_use_stall), 32'(lus));
        if (m.valid) begin
            chk("m_a", u_if.ex_a, m.s1 ? {27'b0, m.sh} : fa);
            chk("m_b", u_if.ex_b, m.s2 ? m.imm : fb);
            chk("m_store", u_if.ex_store_data, fb);
            chk("m_alufun", 32'(u_if.ex_alufun), 32'(m.fun));
            chk("m_sign", 32'(u_if.ex_sign), 32'(m.sgn));
            chk("m_rd", 32'(u_if.ex_rd), 32'(m.rd));
        end
        m_nx = m;
        if (x.stall) begin
            m_nx.rsd = fa;
            m_nx.rtd = fb;
        end else if (x.flush || lus || !x.idv) begin
            m_nx.valid = 1'b0;
            m_nx.rw    = 1'b0;
            m_nx.mr    = 1'b0;
        end else begin
            m_nx = '{valid: 1'b1, rsd: x.rsd, rtd: x.rtd, imm: x.imm, sh: x.sh, rs: x.rs,
                     rt: x.rt, rd: x.rd, fun: x.fun, sgn: x.sgn, s1: x.s1, s2: x.s2,
                     rw: x.rw, mr: x.mr};
        end
    endtask

    task automatic mc_clock();
        @(posedge clk);
        #1;
        m = m_nx;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Directed vectors; expectations refer to the instruction already in EX
        tbl[0]  = ex(ins(1, 1, 32'd5, 2, 32'd7, 3, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = ex(ins(1, 3, 32'h99, 0, 32'd4, 6, 0, 0, 0, 0, 1, 0), 1, 1, 1, 0, 32'd5, 32'd7, 32'd7);
        tbl[2]  = ex(fw(ins(1, 3, 32'h99, 0, 32'd4, 6, 0, 0, 0, 0, 1, 0), 1, 3, 32'h11, 1, 3, 32'h22),
                     1, 1, 1, 0, 32'h11, 32'd4, 32'd4);
        tbl[3]  = ex(fw(ins(1, 0, 32'h77, 0, 32'h33, 6, 0, 0, 0, 0, 1, 0), 0, 3, 32'h11, 1, 3, 32'h22),
                     1, 1, 1, 0, 32'h22, 32'd4, 32'd4);
        tbl[4]  = ex(fw(ins(1, 1, 32'hAAAA, 5, 32'hAB, 9, 1, 9, 1, 32'h1234, 0, 0), 1, 0, 32'h11, 1, 0, 32'h22),
                     1, 1, 1, 0, 32'h77, 32'h33, 32'h33);
        tbl[5]  = ex(fw(ins(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1, 1), 1, 5, 32'hCC, 0, 0, 0),
                     1, 1, 0, 0, 32'd9, 32'h1234, 32'hCC);
        tbl[6]  = ex(ins(1, 0, 0, 8, 32'h1, 2, 0, 0, 0, 0, 1, 0), 0, 1, 1, 1, 0, 0, 0);
        tbl[7]  = ex(ins(1, 0, 0, 8, 32'h2, 2, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = ex(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, 0, 32'd0, 32'd2, 32'd2);
        tbl[9]  = ex(ins(1, 0, 32'd5, 0, 32'd6, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = ex(ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 1, 1, 0, 32'd5, 32'd6, 32'd6);

        // Reset state, no clock edge needed
        #11;
        chk("rst_valid", 32'(u_if.ex_valid), 32'd0);
        chk("rst_regwrite", 32'(u_if.ex_regwrite), 32'd0);
        chk("rst_memread", 32'(u_if.ex_memread), 32'd0);
        chk("rst_load_use", 32'(u_if.load_use_stall), 32'd0);
        chk("rst_a", u_if.ex_a, 32'd0);
        chk("rst_b", u_if.ex_b, 32'd0);
        chk("rst_alufun", 32'(u_if.ex_alufun), 32'd0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #3;
            chk($sformatf("tbl%0d_valid", i), 32'(u_if.ex_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_regwrite", i), 32'(u_if.ex_regwrite), 32'(tbl[i].erw));
            chk($sformatf("tbl%0d_load_use", i), 32'(u_if.load_use_stall), 32'(tbl[i].elus));
            if (tbl[i].cd) begin
                chk($sformatf("tbl%0d_a", i), u_if.ex_a, tbl[i].ea);
                chk($sformatf("tbl%0d_b", i), u_if.ex_b, tbl[i].eb);
                chk($sformatf("tbl%0d_store", i), u_if.ex_store_data, tbl[i].est);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset during a stall discards the held instruction
        v = ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v.stall = 1'b1;
        drive(v);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", 32'(u_if.ex_valid), 32'd0);
        chk("areset_a", u_if.ex_a, 32'd0);
        chk("areset_b", u_if.ex_b, 32'd0);
        chk("areset_regwrite", 32'(u_if.ex_regwrite), 32'd0);
        @(posedge clk);
        #1;
        chk("areset_hold_valid", 32'(u_if.ex_valid), 32'd0);
        #2;
        reset = 1'b1;
        m = '{valid: 1'b0, rsd: '0, rtd: '0, imm: '0, sh: '0, rs: '0, rt: '0, rd: '0,
              fun: '0, sgn: 1'b0, s1: 1'b0, s2: 1'b0, rw: 1'b0, mr: 1'b0};

        // Stall keeps forwarded data after the forwarding source disappears
        mc_drive(ins(1, 4, 32'h10, 0, 32'd1, 7, 0, 0, 0, 0, 1, 0));
        mc_clock();
        v = ins(1, 1, 0, 2, 0, 3, 0, 0, 0, 0, 1, 0);
        v.stall = 1'b1; v.wrw = 1'b1; v.wrd = 5'd4; v.wres = 32'h55;
        mc_drive(v);
        chk("stall_fwd_c1", u_if.ex_a, 32'h55);
        mc_clock();
        v.wrw = 1'b0; v.wres = 32'h0;
        mc_drive(v);
        chk("stall_fwd_c2", u_if.ex_a, 32'h55);
        mc_clock();

        // Stall overrides flush; flush alone inserts a bubble
        v.flush = 1'b1;
        mc_drive(v);
        mc_clock();
        v.stall = 1'b0;
        mc_drive(v);
        chk("stall_flush_held", 32'(u_if.ex_valid), 32'd1);
        mc_clock();
        mc_drive(ins(1, 1, 32'h3, 2, 32'h4, 5, 0, 0, 0, 0, 1, 0));
        chk("flush_bubble", 32'(u_if.ex_valid), 32'd0);
        mc_clock();

        // Randomized traffic with a small register namespace to provoke hazards
        for (int n = 0; n < 400; n++) begin
            v = '{default: '0};
            v.idv   = ($urandom_range(0, 9) != 0);
            v.rsd   = $urandom;
            v.rtd   = $urandom;
            v.imm   = $urandom;
            v.sh    = 5'($urandom);
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.fun   = 6'($urandom);
            v.sgn   = 1'($urandom_range(0, 1));
            v.s1    = ($urandom_range(0, 3) == 0);
            v.s2    = ($urandom_range(0, 3) == 0);
            v.rw    = 1'($urandom_range(0, 1));
            v.mr    = ($urandom_range(0, 2) == 0);
            v.mrw   = 1'($urandom_range(0, 1));
            v.mrd   = 5'($urandom_range(0, 3));
            v.mres  = $urandom;
            v.wrw   = 1'($urandom_range(0, 1));
            v.wrd   = 5'($urandom_range(0, 3));
            v.wres  = $urandom;
            v.stall = ($urandom_range(0, 4) == 0);
            v.flush = ($urandom_range(0, 6) == 0);
            mc_drive(v);
            mc_clock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
